// File: rtl/mem_pkg.sv
// Shared definitions for the IF/LS data-memory arbiter: width codes, owner tags and the
// LS access legality check.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Flags both misaligned and illegal accesses; unsigned widths are load-only.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                         input logic we);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = we;
      F3_HU:   bad = we | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_owner_pipe.sv
// Read-ownership tag delay line: a tag pushed with a read strobe emerges MEM_LAT cycles
// later, aligned with the memory's read data.
module mem_owner_pipe
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [MEM_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port data memory between instruction fetch and load/store, routes read
// data back to the issuing port and answers rejected LS accesses without touching memory.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [3:0]  starve_q, starve_d;
  logic        hold_q, hold_d, hold_err_q, hold_err_d;
  logic        if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic        ls_bad, ls_ok, ls_resp, ls_ret, if_ret;
  tag_t        tag_in, tag_out;

  assign ls_bad = is_misaligned(ls_funct3, ls_addr[1:0], ls_we);
  // A full hold register blocks LS so at most one non-read response is ever waiting.
  assign ls_ok  = ls_req & ~hold_q & ~rst;
  assign if_gnt = if_req & ~rst & (~ls_ok | (starve_q == StarveMax));
  assign ls_gnt = ls_ok & ~if_gnt;

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_funct3 = 3'd0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    if (if_gnt) begin
      mem_en     = 1'b1;
      mem_funct3 = F3_W;
      mem_addr   = if_addr;
    end else if (ls_gnt && !ls_bad) begin
      mem_en     = 1'b1;
      mem_we     = ls_we;
      mem_funct3 = ls_funct3;
      mem_addr   = ls_addr;
      mem_wdata  = ls_wdata;
    end
  end

  assign tag_in.valid = mem_en & ~mem_we;
  assign tag_in.owner = ls_gnt ? OWN_LS : OWN_IF;

  mem_owner_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_owner_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign if_ret  = tag_out.valid & (tag_out.owner == OWN_IF);
  assign ls_ret  = tag_out.valid & (tag_out.owner == OWN_LS);
  // Error or store acknowledge, due on the LS port next cycle.
  assign ls_resp = ls_gnt & (ls_bad | ls_we);

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_gnt) begin
      starve_d = 4'd0;
    end else if (ls_gnt && !ls_bad && starve_q != StarveMax) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    if_rvalid_d = if_ret;
    if_rdata_d  = if_ret ? mem_rdata : if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    hold_d      = hold_q;
    hold_err_d  = hold_err_q;
    if (ls_ret) begin
      ls_rvalid_d = 1'b1;
      ls_rdata_d  = mem_rdata;
      if (ls_resp) begin
        hold_d     = 1'b1;
        hold_err_d = ls_bad;
      end
    end else if (hold_q) begin
      ls_rvalid_d = 1'b1;
      ls_err_d    = hold_err_q;
      hold_d      = 1'b0;
      if (hold_err_q) ls_rdata_d = 32'd0;
    end else if (ls_resp) begin
      ls_rvalid_d = 1'b1;
      ls_err_d    = ls_bad;
      if (ls_bad) ls_rdata_d = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= 4'd0;
      hold_q      <= 1'b0;
      hold_err_q  <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= 32'd0;
      ls_err_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      hold_q      <= hold_d;
      hold_err_q  <= hold_err_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

  // Outputs read as zero throughout a reset cycle, not only after it.
  assign if_rvalid = if_rvalid_q & ~rst;
  assign if_rdata  = rst ? 32'd0 : if_rdata_q;
  assign ls_rvalid = ls_rvalid_q & ~rst;
  assign ls_rdata  = rst ? 32'd0 : ls_rdata_q;
  assign ls_err    = ls_err_q & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vectors and sequences, then random traffic scored against a
// cycle-indexed response model with a behavioural latency-LAT memory.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int unsigned LAT  = 3;
  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_funct3, mem_funct3;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .MEM_LAT    (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_funct3  (ls_funct3),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_err     (ls_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Behavioural memory: 512 bytes, read data appears LAT cycles after the strobe.
  logic [31:0] memw [128];
  logic [31:0] rd_pipe [LAT];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return memw[a[8:2]];
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = rd_word(a) >> {a[1:0], 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [2:0] f3);
    logic [31:0] r;
    r = w;
    case (f3)
      3'd0:    r[{a[1:0], 3'b000} +: 8] = d[7:0];
      3'd1:    r[{a[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) memw[mem_addr[8:2]] <= merge(rd_word(mem_addr), mem_addr, mem_wdata,
                                                      mem_funct3);
    rd_pipe[0] <= (mem_en && !mem_we) ? load_val(mem_addr, mem_funct3) : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
  endtask

  task automatic ls_drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = a; ls_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Independent legality rule for the model.
  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return (f3 == 3'd0) || (f3 == 3'd4 && !we) || (f3 == 3'd2 && a[1:0] == 2'b00) ||
           ((f3 == 3'd1 || (f3 == 3'd5 && !we)) && !a[0]);
  endfunction

  typedef struct packed {
    logic        if_req;
    logic        ls_req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        e_if;
    logic        e_ls;
    logic        e_en;
  } vec_t;

  vec_t tbl [15];

  // Random-phase model state.
  logic [31:0] exp_if_at [int];
  logic [31:0] exp_ls_at [int];
  logic        pend, pend_err, if_pend, ls_pend, r_we;
  int          pend_from, starve;
  logic [31:0] if_last, ls_last, r_ifa, r_lsa, r_wd;
  logic [2:0]  r_f3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++) memw[i] <= 32'h5A5A_0000 ^ (i * 32'h0101_0033);
    memw[64] <= 32'hDEAD_BEEF;
    memw[65] <= 32'h0BAD_F00D;
    memw[17] <= 32'h8765_4321;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h040, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'd2, 32'h040, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd2, 32'h102, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h101, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd1, 32'h102, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 32'h103, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'd0, 32'h041, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd3, 32'h040, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 3'd4, 32'h040, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h041, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 32'h043, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 3'd1, 32'h042, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd7, 32'h040, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 32'h000, 1'b0, 1'b0, 1'b0};

    do_reset();
    chk("post_reset_if_rvalid", if_rvalid, 1'b0);
    chk("post_reset_ls_rvalid", ls_rvalid, 1'b0);
    chk("post_reset_ls_rdata", ls_rdata, 32'd0);

    // Combinational vectors; inputs return to idle before each edge so no state changes.
    for (int i = 0; i < 15; i++) begin
      tick();
      if_req = tbl[i].if_req; if_addr = tbl[i].addr;
      ls_req = tbl[i].ls_req; ls_we = tbl[i].we; ls_funct3 = tbl[i].f3;
      ls_addr = tbl[i].addr; ls_wdata = 32'hCAFE_F00D;
      #1;
      chk($sformatf("vec%0d_if_gnt", i), if_gnt, tbl[i].e_if);
      chk($sformatf("vec%0d_ls_gnt", i), ls_gnt, tbl[i].e_ls);
      chk($sformatf("vec%0d_mem_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].e_en & tbl[i].we & ~tbl[i].e_if);
      chk($sformatf("vec%0d_mem_f3", i), mem_funct3,
          tbl[i].e_en ? (tbl[i].e_if ? 3'd2 : tbl[i].f3) : 3'd0);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].e_en ? tbl[i].addr : 32'd0);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata,
          (tbl[i].e_en && !tbl[i].e_if) ? 32'hCAFE_F00D : 32'd0);
      idle();
    end

    // IF-only fetch: data returns LAT+1 cycles after the grant.
    tick();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("t1_if_gnt", if_gnt, 1'b1);
    chk("t1_mem_f3", mem_funct3, 3'd2);
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      idle();
      chk($sformatf("t1_if_rvalid_c%0d", k), if_rvalid, k == LAT + 1);
    end
    chk("t1_if_rdata", if_rdata, 32'hDEAD_BEEF);

    // Contention: four LS grants, then IF is forced through, then LS again.
    for (int k = 0; k < 7; k++) begin
      if_req = 1'b1; if_addr = 32'h104;
      ls_drive(1'b0, 3'd2, 32'h040, 32'd0);
      #1;
      chk($sformatf("t2_if_gnt_c%0d", k), if_gnt, k == 4);
      chk($sformatf("t2_ls_gnt_c%0d", k), ls_gnt, k != 4);
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    // Misaligned LW: granted without a memory access, error next cycle.
    ls_drive(1'b0, 3'd2, 32'h102, 32'd0);
    #1;
    chk("t3_ls_gnt", ls_gnt, 1'b1);
    chk("t3_mem_en", mem_en, 1'b0);
    tick();
    idle();
    chk("t3_ls_rvalid", ls_rvalid, 1'b1);
    chk("t3_ls_err", ls_err, 1'b1);
    chk("t3_ls_rdata", ls_rdata, 32'd0);
    tick();
    chk("t3_ls_rvalid_done", ls_rvalid, 1'b0);

    // Interleaved IF, LS, IF issue; each read returns to its own port in order.
    for (int k = 0; k <= 6; k++) begin
      idle();
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h100; end
      if (k == 1) ls_drive(1'b0, 3'd2, 32'h044, 32'd0);
      if (k == 2) begin if_req = 1'b1; if_addr = 32'h104; end
      #1;
      chk($sformatf("t4_if_rvalid_c%0d", k), if_rvalid, k == 4 || k == 6);
      chk($sformatf("t4_ls_rvalid_c%0d", k), ls_rvalid, k == 5);
      if (k == 0 || k == 2) chk($sformatf("t4_if_gnt_c%0d", k), if_gnt, 1'b1);
      if (k == 1) chk("t4_ls_gnt", ls_gnt, 1'b1);
      if (k == 4) chk("t4_if_rdata_a", if_rdata, 32'hDEAD_BEEF);
      if (k == 5) chk("t4_ls_rdata", ls_rdata, 32'h8765_4321);
      if (k == 6) chk("t4_if_rdata_b", if_rdata, 32'h0BAD_F00D);
      tick();
    end

    // Store acknowledge, then read-back of the stored word.
    for (int k = 0; k <= 5; k++) begin
      idle();
      if (k == 0) ls_drive(1'b1, 3'd2, 32'h040, 32'h1234_5678);
      if (k == 1) ls_drive(1'b0, 3'd2, 32'h040, 32'd0);
      #1;
      if (k <= 1) chk($sformatf("t5_ls_gnt_c%0d", k), ls_gnt, 1'b1);
      if (k == 0) chk("t5_mem_we", mem_we, 1'b1);
      chk($sformatf("t5_ls_rvalid_c%0d", k), ls_rvalid, k == 1 || k == 5);
      if (k == 1) chk("t5_store_err", ls_err, 1'b0);
      if (k == 5) chk("t5_load_rdata", ls_rdata, 32'h1234_5678);
      tick();
    end

    // Error grant whose response collides with a load return: load first, error one cycle later.
    for (int k = 0; k <= 5; k++) begin
      idle();
      if (k == 0) ls_drive(1'b0, 3'd2, 32'h048, 32'd0);
      if (k == 3) ls_drive(1'b0, 3'd1, 32'h043, 32'd0);
      if (k >= 4) ls_drive(1'b0, 3'd2, 32'h04C, 32'd0);
      #1;
      if (k == 3) chk("t7_err_gnt", ls_gnt, 1'b1);
      if (k == 4) begin
        chk("t7_gnt_blocked", ls_gnt, 1'b0);
        chk("t7_rd_rvalid", ls_rvalid, 1'b1);
        chk("t7_rd_err", ls_err, 1'b0);
        chk("t7_rd_data", ls_rdata, load_val(32'h048, 3'd2));
      end
      if (k == 5) begin
        chk("t7_gnt_resumed", ls_gnt, 1'b1);
        chk("t7_err_rvalid", ls_rvalid, 1'b1);
        chk("t7_err_err", ls_err, 1'b1);
        chk("t7_err_rdata", ls_rdata, 32'd0);
      end
      tick();
    end
    idle();
    repeat (LAT + 2) tick();

    // Reset one cycle after a read grant: outputs zero during reset, no late rvalid.
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("t6_if_gnt", if_gnt, 1'b1);
    tick();
    rst = 1'b1;
    ls_drive(1'b0, 3'd2, 32'h040, 32'd0);
    #1;
    chk("t6_rst_if_gnt", if_gnt, 1'b0);
    chk("t6_rst_ls_gnt", ls_gnt, 1'b0);
    chk("t6_rst_mem_en", mem_en, 1'b0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_if_rdata", if_rdata, 32'd0);
    chk("t6_rst_ls_rdata", ls_rdata, 32'd0);
    chk("t6_rst_rvalids", {if_rvalid, ls_rvalid, ls_err}, 3'b000);
    tick();
    rst = 1'b0;
    idle();
    for (int k = 0; k < LAT + 2; k++) begin
      #1;
      chk($sformatf("t6_no_rvalid_c%0d", k), {if_rvalid, ls_rvalid}, 2'b00);
      tick();
    end

    // Random traffic against the response-scheduling model.
    do_reset();
    pend = 1'b0; pend_err = 1'b0; pend_from = 0; starve = 0;
    if_pend = 1'b0; ls_pend = 1'b0; if_last = '0; ls_last = '0;
    r_ifa = '0; r_lsa = '0; r_wd = '0; r_f3 = '0; r_we = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic e_if, e_ls, e_lsv, e_err, hold_full, ok, ifr;
      e_lsv = 1'b0;
      e_err = 1'b0;
      if (exp_if_at.exists(cyc)) begin
        if_last = exp_if_at[cyc];
        exp_if_at.delete(cyc);
        chk("rnd_if_rvalid", if_rvalid, 1'b1);
      end else begin
        chk("rnd_if_rvalid", if_rvalid, 1'b0);
      end
      chk("rnd_if_rdata", if_rdata, if_last);
      if (exp_ls_at.exists(cyc)) begin
        e_lsv = 1'b1;
        ls_last = exp_ls_at[cyc];
        exp_ls_at.delete(cyc);
      end else if (pend && pend_from <= cyc) begin
        e_lsv = 1'b1;
        e_err = pend_err;
        if (pend_err) ls_last = '0;
        pend = 1'b0;
      end
      chk("rnd_ls_rvalid", ls_rvalid, e_lsv);
      if (e_lsv) chk("rnd_ls_err", ls_err, e_err);
      chk("rnd_ls_rdata", ls_rdata, ls_last);
      hold_full = pend && pend_from <= cyc;

      if (cyc < 1990) begin
        if (!if_pend && $urandom_range(0, 99) < 60) begin
          if_pend = 1'b1;
          r_ifa = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
        end
        if (!ls_pend && $urandom_range(0, 99) < 60) begin
          ls_pend = 1'b1;
          r_we = ($urandom_range(0, 2) == 0);
          r_f3 = 3'($urandom_range(0, 7));
          r_lsa = 32'($urandom_range(0, 511));
          r_wd = $urandom;
        end
      end
      idle();
      if_req = if_pend; if_addr = if_pend ? r_ifa : '0;
      if (ls_pend) ls_drive(r_we, r_f3, r_lsa, r_wd);
      #1;

      ok = legal(r_we, r_f3, r_lsa);
      ifr = if_pend;
      e_ls = ls_pend && !hold_full;
      e_if = if_pend && (!e_ls || starve == SMAX);
      e_ls = e_ls && !e_if;
      chk("rnd_if_gnt", if_gnt, e_if);
      chk("rnd_ls_gnt", ls_gnt, e_ls);
      if (e_if) begin
        chk("rnd_mem_ctl", {mem_en, mem_we, mem_funct3}, {1'b1, 1'b0, 3'd2});
        chk("rnd_mem_addr", mem_addr, r_ifa);
        chk("rnd_mem_wdata", mem_wdata, 32'd0);
        exp_if_at[cyc + LAT + 1] = rd_word(r_ifa);
        if_pend = 1'b0;
      end else if (e_ls && ok) begin
        chk("rnd_mem_ctl", {mem_en, mem_we, mem_funct3}, {1'b1, r_we, r_f3});
        chk("rnd_mem_addr", mem_addr, r_lsa);
        chk("rnd_mem_wdata", mem_wdata, r_wd);
      end else begin
        chk("rnd_mem_ctl", {mem_en, mem_we, mem_funct3}, 5'd0);
        chk("rnd_mem_addr", mem_addr, 32'd0);
      end
      if (e_ls) begin
        ls_pend = 1'b0;
        if (!ok || r_we) begin
          pend = 1'b1;
          pend_err = !ok;
          pend_from = cyc + 1;
        end else begin
          exp_ls_at[cyc + LAT + 1] = load_val(r_lsa, r_f3);
        end
      end
      if (!ifr || e_if) starve = 0;
      else if (e_ls && ok && starve < SMAX) starve++;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
